// File: rtl/fpu_issue.sv
// fpu_issue: issue/response sequencer between an in-order core and an FP unit.
// Takes one request at a time from the core, presents it to the unit with a
// held order strobe, and returns the unit result (or a timeout error).
//
// Ports
//   clk, rst              clock and synchronous active-high reset
//   req_valid/req_ready   core request handshake
//   req_rs1/rs2/func3     request operands and operation select
//   resp_valid/resp_ready core response handshake
//   resp_rd, resp_err     response word and timeout flag
//   order                 issue strobe to the unit (high in ISSUE and WAIT)
//   accepted, done        unit handshake inputs
//   rs1, rs2, func3       operands held for the unit
//   rd                    unit result, meaningful only while done=1
//   busy                  high whenever not IDLE
module fpu_issue #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [2:0]  req_func3,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rd,
  output logic        resp_err,
  output logic        order,
  input  logic        accepted,
  input  logic        done,
  output logic [31:0] rs1,
  output logic [31:0] rs2,
  output logic [2:0]  func3,
  input  logic [31:0] rd,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state;
  logic [7:0] cnt;

  // cnt holds the number of earlier order cycles, so the current cycle is
  // the TIMEOUT-th one when cnt equals TIMEOUT-1.
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_rd    <= '0;
      resp_err   <= 1'b0;
      rs1        <= '0;
      rs2        <= '0;
      func3      <= '0;
      order      <= 1'b0;
      busy       <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            rs1       <= req_rs1;
            rs2       <= req_rs2;
            func3     <= req_func3;
            cnt       <= '0;
            state     <= ISSUE;
            order     <= 1'b1;
            busy      <= 1'b1;
            req_ready <= 1'b0;
          end
        end
        ISSUE, WAIT: begin
          cnt <= cnt + 8'd1;
          // done wins over timeout; done in ISSUE doubles as the accept
          if (done) begin
            resp_rd    <= rd;
            resp_err   <= 1'b0;
            state      <= RESP;
            order      <= 1'b0;
            resp_valid <= 1'b1;
          end else if (cnt == LAST) begin
            resp_rd    <= '0;
            resp_err   <= 1'b1;
            state      <= RESP;
            order      <= 1'b0;
            resp_valid <= 1'b1;
          end else if (state == ISSUE && accepted) begin
            state <= WAIT;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_issue.sv
module tb_fpu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_rs1, req_rs2;
  logic [2:0]  req_func3;
  logic        resp_ready;
  logic        accepted, done;
  logic [31:0] rd;

  logic        req_ready, resp_valid, resp_err, order, busy;
  logic [31:0] resp_rd, rs1, rs2;
  logic [2:0]  func3;

  logic        t4_req_ready, t4_resp_valid, t4_resp_err, t4_order, t4_busy;
  logic [31:0] t4_resp_rd, t4_rs1, t4_rs2;
  logic [2:0]  t4_func3;

  logic        t3_req_ready, t3_resp_valid, t3_resp_err, t3_order, t3_busy;
  logic [31:0] t3_resp_rd, t3_rs1, t3_rs2;
  logic [2:0]  t3_func3;

  int unsigned passed = 0;
  int unsigned total  = 0;

  always #5 clk = ~clk;

  fpu_issue dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_func3(req_func3),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rd(resp_rd),
    .resp_err(resp_err), .order(order), .accepted(accepted), .done(done),
    .rs1(rs1), .rs2(rs2), .func3(func3), .rd(rd), .busy(busy)
  );

  fpu_issue #(.TIMEOUT(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(t4_req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_func3(req_func3),
    .resp_valid(t4_resp_valid), .resp_ready(resp_ready), .resp_rd(t4_resp_rd),
    .resp_err(t4_resp_err), .order(t4_order), .accepted(accepted), .done(done),
    .rs1(t4_rs1), .rs2(t4_rs2), .func3(t4_func3), .rd(rd), .busy(t4_busy)
  );

  fpu_issue #(.TIMEOUT(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(t3_req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_func3(req_func3),
    .resp_valid(t3_resp_valid), .resp_ready(resp_ready), .resp_rd(t3_resp_rd),
    .resp_err(t3_resp_err), .order(t3_order), .accepted(accepted), .done(done),
    .rs1(t3_rs1), .rs2(t3_rs2), .func3(t3_func3), .rd(rd), .busy(t3_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // advance one edge and land 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // request offered before the edge, taken on it; returns in cycle 1
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
    req_valid = 1'b1;
    req_rs1   = a;
    req_rs2   = b;
    req_func3 = f;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0; req_func3 = '0;
    resp_ready = 1'b0; accepted = 1'b0; done = 1'b0; rd = '0;
    #2;
    do_reset();

    // reset state
    chk("rst_order", {31'b0, order}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_rd", resp_rd, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_rs1", rs1, 32'd0);
    chk("rst_func3", {29'b0, func3}, 32'd0);

    // comparator-style unit, zero latency
    issue(32'h3F800000, 32'h3F800000, 3'b010);
    chk("cmp_c1_order", {31'b0, order}, 32'd1);
    chk("cmp_c1_busy", {31'b0, busy}, 32'd1);
    chk("cmp_c1_req_ready", {31'b0, req_ready}, 32'd0);
    chk("cmp_c1_rs1", rs1, 32'h3F800000);
    chk("cmp_c1_rs2", rs2, 32'h3F800000);
    chk("cmp_c1_func3", {29'b0, func3}, 32'd2);
    chk("cmp_c1_resp_valid", {31'b0, resp_valid}, 32'd0);
    accepted = 1'b1; done = 1'b1; rd = 32'h1;
    tick();
    accepted = 1'b0; done = 1'b0; rd = 32'hDEADBEEF;
    chk("cmp_c2_order", {31'b0, order}, 32'd0);
    chk("cmp_c2_resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("cmp_c2_resp_rd", resp_rd, 32'h1);
    chk("cmp_c2_resp_err", {31'b0, resp_err}, 32'd0);

    // response back-pressure with a pending new request
    req_valid = 1'b1; req_rs1 = 32'h11111111; req_rs2 = 32'h22222222; req_func3 = 3'b101;
    done = 1'b1; accepted = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_resp_valid", {31'b0, resp_valid}, 32'd1);
      chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
      chk("bp_resp_rd", resp_rd, 32'h1);
      chk("bp_rs1_hold", rs1, 32'h3F800000);
      chk("bp_order", {31'b0, order}, 32'd0);
    end
    done = 1'b0; accepted = 1'b0;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("bp_idle_req_ready", {31'b0, req_ready}, 32'd1);
    chk("bp_idle_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("bp_idle_order", {31'b0, order}, 32'd0);
    tick();
    req_valid = 1'b0;
    chk("bp_new_order", {31'b0, order}, 32'd1);
    chk("bp_new_rs1", rs1, 32'h11111111);
    chk("bp_new_func3", {29'b0, func3}, 32'd5);

    // multi-cycle unit: accepted in cycle 1, done in cycle 5
    do_reset();
    issue(32'h40000000, 32'h3FC90FDB, 3'b000);
    for (int c = 1; c <= 5; c++) begin
      chk("mc_order", {31'b0, order}, 32'd1);
      chk("mc_resp_valid", {31'b0, resp_valid}, 32'd0);
      accepted = (c == 1);
      done     = (c == 5);
      rd       = (c == 5) ? 32'h40490FDB : 32'h0BADF00D;
      tick();
    end
    accepted = 1'b0; done = 1'b0;
    chk("mc_c6_order", {31'b0, order}, 32'd0);
    chk("mc_c6_resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("mc_c6_resp_rd", resp_rd, 32'h40490FDB);
    chk("mc_c6_resp_err", {31'b0, resp_err}, 32'd0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("mc_idle_busy", {31'b0, busy}, 32'd0);

    // timeout with TIMEOUT=4, unit never finishes
    do_reset();
    issue(32'h1, 32'h2, 3'b001);
    rd = 32'h55555555;
    for (int c = 1; c <= 4; c++) begin
      chk("to4_order", {31'b0, t4_order}, 32'd1);
      chk("to4_resp_valid", {31'b0, t4_resp_valid}, 32'd0);
      tick();
    end
    chk("to4_c5_order", {31'b0, t4_order}, 32'd0);
    chk("to4_c5_resp_valid", {31'b0, t4_resp_valid}, 32'd1);
    chk("to4_c5_resp_err", {31'b0, t4_resp_err}, 32'd1);
    chk("to4_c5_resp_rd", t4_resp_rd, 32'd0);

    // TIMEOUT=3 with done on the third order cycle: done wins
    do_reset();
    issue(32'h3, 32'h4, 3'b011);
    tick();
    tick();
    chk("to3_c3_order", {31'b0, t3_order}, 32'd1);
    done = 1'b1; rd = 32'hC0FFEE01;
    tick();
    done = 1'b0;
    chk("to3_c4_resp_valid", {31'b0, t3_resp_valid}, 32'd1);
    chk("to3_c4_resp_err", {31'b0, t3_resp_err}, 32'd0);
    chk("to3_c4_resp_rd", t3_resp_rd, 32'hC0FFEE01);

    // reset while in WAIT drops the operation
    do_reset();
    issue(32'h7, 32'h8, 3'b100);
    accepted = 1'b1;
    tick();
    accepted = 1'b0;
    chk("rw_wait_order", {31'b0, order}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rw_order", {31'b0, order}, 32'd0);
    chk("rw_busy", {31'b0, busy}, 32'd0);
    chk("rw_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rw_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rw_rs1", rs1, 32'd0);
    // done in IDLE must not produce a response
    done = 1'b1; accepted = 1'b1; rd = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rw_idle_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("rw_idle_resp_rd", resp_rd, 32'd0);
    end
    done = 1'b0; accepted = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
